// File: rtl/freq_counter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : freq_counter_pkg
// Purpose  : Shared constants and FSM encoding for the gated frequency counter.
// Revision : 1.0 - initial release
// ============================================================================
package freq_counter_pkg;

  localparam int DISP_MAX = 9999;
  localparam int DISP_W   = 16;
  localparam int COUNT_W  = 14;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    CONVERT = 2'd2
  } fsm_state_t;

endpackage
`default_nettype wire

// File: rtl/freq_gate_counter_bin2bcd.sv
`default_nettype none
// ============================================================================
// Module   : bin2bcd_seq
// Purpose  : Serial double-dabble converter, 14-bit binary to 4-digit packed
//            BCD; present only when BCD_OUT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`ifdef BCD_OUT_EN
module bin2bcd_seq
  import freq_counter_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [COUNT_W-1:0] bin,
  output logic               done,
  output logic [DISP_W-1:0]  bcd
);

  localparam int c_cnt_w = $clog2(COUNT_W);
  localparam logic [c_cnt_w-1:0] c_shifts_left = c_cnt_w'(COUNT_W - 1);

  logic [COUNT_W-1:0] r_bin;
  logic [DISP_W-1:0]  r_bcd;
  logic [DISP_W-1:0]  w_adj;
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_done;

  for (genvar i = 0; i < DISP_W / 4; i++) begin : g_nibble
    assign w_adj[4*i +: 4] = (r_bcd[4*i +: 4] >= 4'd5) ? r_bcd[4*i +: 4] + 4'd3
                                                       : r_bcd[4*i +: 4];
  end

  // The load performs the first shift (adjust of an all-zero BCD is a no-op),
  // so the whole conversion completes 14 cycles after start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bin  <= '0;
      r_bcd  <= '0;
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (start) begin
        r_bcd <= {{(DISP_W-1){1'b0}}, bin[COUNT_W-1]};
        r_bin <= {bin[COUNT_W-2:0], 1'b0};
        r_cnt <= c_shifts_left;
      end else if (r_cnt != '0) begin
        r_bcd <= {w_adj[DISP_W-2:0], r_bin[COUNT_W-1]};
        r_bin <= {r_bin[COUNT_W-2:0], 1'b0};
        r_cnt <= r_cnt - 1'b1;
        if (r_cnt == c_cnt_w'(1)) r_done <= 1'b1;
      end
    end
  end

  assign done = r_done;
  assign bcd  = r_bcd;

endmodule
`endif
`default_nettype wire

// File: rtl/freq_gate_counter.sv
`default_nettype none
// ============================================================================
// Module   : freq_gate_counter
// Purpose  : Counts sig_in rising edges over a fixed gate window and publishes
//            the saturated count. Option macro: BCD_OUT_EN (packed BCD output).
// Revision : 1.0 - initial release
// ============================================================================
module freq_gate_counter
  import freq_counter_pkg::*;
#(
  parameter int CLK_HZ    = 100_000_000,
  parameter int GATE_MS   = 1000,
  parameter int MAX_COUNT = 9999
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sig_in,
  input  logic              enable,
  output logic [DISP_W-1:0] displayed_number,
  output logic              update,
  output logic              overflow
);

  localparam int GATE_CYCLES = CLK_HZ / 1000 * GATE_MS;
  localparam int GATE_W      = $clog2(GATE_CYCLES);
  localparam logic [GATE_W-1:0]  c_gate_last = GATE_W'(GATE_CYCLES - 1);
  localparam logic [COUNT_W-1:0] c_max_count = COUNT_W'(MAX_COUNT);

  logic               r_s1, r_s2, r_s3;
  logic               w_edge;
  fsm_state_t         r_state, w_state_next;
  logic [GATE_W-1:0]  r_gate;
  logic [COUNT_W-1:0] r_count, w_count_inc;
  logic               w_sat, w_close, w_counting, w_run;
  logic [DISP_W-1:0]  r_display;
  logic               r_update, r_overflow;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= sig_in;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign w_edge      = r_s2 & ~r_s3;
  assign w_count_inc = (w_edge && (r_count != c_max_count)) ? r_count + 1'b1 : r_count;
  assign w_sat       = (w_count_inc == c_max_count);
  assign w_close     = (r_state == MEASURE) && (r_gate == c_gate_last);

`ifdef BCD_OUT_EN
  // The following window keeps measuring while the converter is busy.
  assign w_counting = (r_state == MEASURE) || (r_state == CONVERT);
`else
  assign w_counting = (r_state == MEASURE);
`endif
  assign w_run = w_counting && enable && (r_gate != c_gate_last);

  // Anything other than a running window (idle, disabled, gate close) restarts at 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_gate  <= '0;
      r_count <= '0;
    end else if (w_run) begin
      r_gate  <= r_gate + 1'b1;
      r_count <= w_count_inc;
    end else begin
      r_gate  <= '0;
      r_count <= '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

`ifdef BCD_OUT_EN
  logic              w_conv_done;
  logic [DISP_W-1:0] w_bcd;
  logic              r_sat_hold;

  bin2bcd_seq u_bin2bcd (
    .clk   (clk),
    .reset (reset),
    .start (w_close),
    .bin   (w_count_inc),
    .done  (w_conv_done),
    .bcd   (w_bcd)
  );
`endif

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (enable) w_state_next = MEASURE;
      end
      MEASURE: begin
        if (w_close) begin
`ifdef BCD_OUT_EN
          w_state_next = CONVERT;
`else
          w_state_next = enable ? MEASURE : IDLE;
`endif
        end else if (!enable) begin
          w_state_next = IDLE;
        end
      end
`ifdef BCD_OUT_EN
      CONVERT: begin
        if (w_conv_done) w_state_next = enable ? MEASURE : IDLE;
      end
`endif
      default: w_state_next = IDLE;
    endcase
  end

`ifdef BCD_OUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_display  <= '0;
      r_update   <= 1'b0;
      r_overflow <= 1'b0;
      r_sat_hold <= 1'b0;
    end else begin
      r_update <= w_conv_done;
      if (w_close) r_sat_hold <= w_sat;
      if (w_conv_done) begin
        r_display  <= w_bcd;
        r_overflow <= r_sat_hold;
      end
    end
  end
`else
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_display  <= '0;
      r_update   <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_update <= w_close;
      if (w_close) begin
        r_display  <= {{(DISP_W-COUNT_W){1'b0}}, w_count_inc};
        r_overflow <= w_sat;
      end
    end
  end
`endif

  assign displayed_number = r_display;
  assign update           = r_update;
  assign overflow         = r_overflow;

endmodule
`default_nettype wire
